// File: rtl/if_fetch_unit.sv
// Instruction fetch front end. Keeps at most one memory request outstanding and
// buffers one instruction word for decode; redirects drain an in-flight request.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ID_pc_mux_sel,
    input  logic [31:0] ID_jmp_pc,
    input  logic        flush,
    input  logic        stall,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_instr,
    output logic        IF_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] req_addr_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_instr_r;
    logic        if_valid_r;

    logic        blocked_s;
    logic        req_s;
    logic        resp_s;
    logic        clear_s;
    logic [31:0] target_s;
    logic [31:0] pc_inc_s;

    assign IF_pc    = if_pc_r;
    assign IF_instr = if_instr_r;
    assign IF_valid = if_valid_r;

    // Request decode: FETCH stands down while the single buffer entry is stuck.
    always_comb begin
        blocked_s = if_valid_r && stall;
        target_s  = ID_jmp_pc & 32'hFFFF_FFFC;
        pc_inc_s  = pc_r + 32'd4;
        clear_s   = ID_pc_mux_sel || flush || (if_valid_r && !stall);
        case (state_r)
            FETCH:   req_s = !blocked_s;
            WAIT:    req_s = 1'b1;
            DROP:    req_s = 1'b1;
            HOLD:    req_s = 1'b0;
            default: req_s = 1'b0;
        endcase
        resp_s = req_s && imem_resp;
        if (!rst_n) begin
            imem_read    = 1'b0;
            imem_address = 32'h0000_0000;
        end else begin
            imem_read    = req_s;
            imem_address = (state_r == FETCH) ? pc_r : req_addr_r;
        end
    end

    // Fetch FSM, PC and the decode-facing instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= FETCH;
            pc_r       <= RESET_PC;
            req_addr_r <= 32'h0000_0000;
            if_pc_r    <= 32'h0000_0000;
            if_instr_r <= 32'h0000_0000;
            if_valid_r <= 1'b0;
        end else begin
            case (state_r)
                FETCH, WAIT: begin
                    if (!req_s) begin
                        if (ID_pc_mux_sel) pc_r <= target_s;
                        if (clear_s) if_valid_r <= 1'b0;
                        state_r <= (ID_pc_mux_sel || flush) ? FETCH : HOLD;
                    end else if (resp_s) begin
                        if (ID_pc_mux_sel) begin
                            pc_r       <= target_s;
                            if_valid_r <= 1'b0;
                            state_r    <= FETCH;
                        end else begin
                            if_pc_r    <= pc_r;
                            if_instr_r <= imem_rdata;
                            if_valid_r <= 1'b1;
                            pc_r       <= pc_inc_s;
                            state_r    <= stall ? HOLD : FETCH;
                        end
                    end else begin
                        if (state_r == FETCH) req_addr_r <= pc_r;
                        if (clear_s) if_valid_r <= 1'b0;
                        if (ID_pc_mux_sel) begin
                            pc_r    <= target_s;
                            state_r <= DROP;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                DROP: begin
                    // The stale response is consumed and thrown away here.
                    if (ID_pc_mux_sel) pc_r <= target_s;
                    if (clear_s) if_valid_r <= 1'b0;
                    if (imem_resp) state_r <= FETCH;
                end
                HOLD: begin
                    if (ID_pc_mux_sel) pc_r <= target_s;
                    if (ID_pc_mux_sel || flush || !stall) begin
                        if_valid_r <= 1'b0;
                        state_r    <= FETCH;
                    end
                end
                default: begin
                    state_r <= FETCH;
                end
            endcase
        end
    end

endmodule
